// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for the whole bus cycle (cyc high), so bursts and RMW
// sequences stay atomic. Priority rotates after every completed cycle.
// Optional stalled-slave watchdog: define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic [NUM_MASTERS*AW-1:0]  wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]  wbm_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]     wbm_we_i,
   input  logic [NUM_MASTERS-1:0]     wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]     wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]   wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]   wbm_bte_i,
   output logic [DW-1:0]              wbm_dat_o,
   output logic [NUM_MASTERS-1:0]     wbm_ack_o,
   output logic [NUM_MASTERS-1:0]     wbm_err_o,
   output logic [NUM_MASTERS-1:0]     wbm_rty_o,
   output logic [AW-1:0]              wbs_adr_o,
   output logic [DW-1:0]              wbs_dat_o,
   output logic [DW/8-1:0]            wbs_sel_o,
   output logic                       wbs_we_o,
   output logic                       wbs_cyc_o,
   output logic                       wbs_stb_o,
   output logic [2:0]                 wbs_cti_o,
   output logic [1:0]                 wbs_bte_o,
   input  logic [DW-1:0]              wbs_dat_i,
   input  logic                       wbs_ack_i,
   input  logic                       wbs_err_i,
   input  logic                       wbs_rty_i,
   output logic [NUM_MASTERS-1:0]     grant_o
);

   localparam int unsigned NM = NUM_MASTERS;
   localparam int          IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int          SW = DW / 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] gnt_idx_q, gnt_idx_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] cand;
   logic [IW-1:0] sel_idx;
   logic          found;
   logic          busy;
   logic          gnt_cyc;
   logic          tmo_hit;

   assign busy    = (state_q == BUSY);
   assign gnt_cyc = busy & wbm_cyc_i[gnt_idx_q];

   // Next-state: arbitrate from ptr in IDLE, hold the grant in BUSY until cyc drops
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      found     = 1'b0;
      cand      = '0;
      case (state_q)
         IDLE: begin
            for (int unsigned i = 0; i < NM; i++) begin
               cand = IW'((ptr_q + i) % NM);
               if (!found && wbm_cyc_i[cand]) begin
                  found     = 1'b1;
                  gnt_idx_d = cand;
                  state_d   = BUSY;
               end
            end
         end
         BUSY: begin
            if (!wbm_cyc_i[gnt_idx_q]) begin
               state_d = IDLE;
               ptr_d   = (gnt_idx_q == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant index and priority pointer registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         gnt_idx_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
      end
   end

   // Slave-side mux and response routing to the granted master only
   always_comb begin
      sel_idx   = busy ? gnt_idx_q : ptr_q;
      wbs_adr_o = wbm_adr_i[sel_idx*AW +: AW];
      wbs_dat_o = wbm_dat_i[sel_idx*DW +: DW];
      wbs_sel_o = wbm_sel_i[sel_idx*SW +: SW];
      wbs_we_o  = wbm_we_i[sel_idx];
      wbs_cti_o = wbm_cti_i[sel_idx*3 +: 3];
      wbs_bte_o = wbm_bte_i[sel_idx*2 +: 2];
      wbs_cyc_o = gnt_cyc;
      wbs_stb_o = gnt_cyc & wbm_stb_i[gnt_idx_q] & ~tmo_hit;
      wbm_dat_o = wbs_dat_i;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      grant_o   = '0;
      if (busy) grant_o[gnt_idx_q] = 1'b1;
      // responses are gated by the live cyc so a late ack after an abort is dropped
      if (gnt_cyc) begin
         wbm_ack_o[gnt_idx_q] = wbs_ack_i;
         wbm_err_o[gnt_idx_q] = wbs_err_i | tmo_hit;
         wbm_rty_o[gnt_idx_q] = wbs_rty_i;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          slv_resp;

   assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
   assign tmo_hit  = busy && (tmo_cnt_q == CW'(TIMEOUT));

   // Watchdog: count stalled strobe cycles, clear on any response, idle or expiry
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (!busy || slv_resp || tmo_hit)
         tmo_cnt_d = '0;
      else if (wbs_stb_o)
         tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   // Watchdog counter register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) tmo_cnt_q <= '0;
      else          tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B3 arbiter sharing one slave port (the system memory / wb_bfm_memory bus segment) between NUM_MASTERS masters, e.g. OR1200 IBUS, OR1200 DBUS and debug unit.
- Sits in orpsoc_top between the master ports and the single memory slave.
- Holds a grant for the whole bus cycle (cyc high), including CTI bursts.
- Rotates priority after each completed cycle.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT, 255, watchdog limit in cycles; used only with WB_ARB_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- wbm_adr_i  in  NUM_MASTERS*AW  packed master addresses; master n uses slice [n*AW +: AW].
- wbm_dat_i  in  NUM_MASTERS*DW  packed master write data.
- wbm_sel_i  in  NUM_MASTERS*DW/8  packed byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cti_i  in  NUM_MASTERS*3  cycle type identifiers.
- wbm_bte_i  in  NUM_MASTERS*2  burst type extensions.
- wbm_dat_o  out  DW  slave read data, broadcast to all masters.
- wbm_ack_o  out  NUM_MASTERS  acknowledge, granted master only.
- wbm_err_o  out  NUM_MASTERS  error, granted master only.
- wbm_rty_o  out  NUM_MASTERS  retry, granted master only.
- wbs_adr_o  out  AW  slave address.
- wbs_dat_o  out  DW  slave write data.
- wbs_sel_o  out  DW/8  slave byte selects.
- wbs_we_o  out  1  slave write enable.
- wbs_cyc_o  out  1  slave cycle.
- wbs_stb_o  out  1  slave strobe.
- wbs_cti_o  out  3  slave cycle type.
- wbs_bte_o  out  2  slave burst type.
- wbs_dat_i  in  DW  slave read data.
- wbs_ack_i  in  1  slave acknowledge.
- wbs_err_i  in  1  slave error.
- wbs_rty_i  in  1  slave retry.
- grant_o  out  NUM_MASTERS  one-hot current grant, for debug and the monitor.

Behaviour:
- Registers:
  - State: IDLE or BUSY.
  - gnt_idx: index of the current grant.
  - ptr: highest-priority index for the next arbitration.
- Reset (async): state=IDLE, ptr=0, grant_o=0, wbs_cyc_o=0, wbs_stb_o=0, and all ack/err/rty outputs 0.
- IDLE:
  - If any wbm_cyc_i is high, pick the first requester scanning ptr, ptr+1, ..., wrapping modulo NUM_MASTERS.
  - Register that index into gnt_idx and go to BUSY.
  - Arbitration latency: 1 cycle from cyc to slave cyc.
- BUSY:
  - Slave-side signals are a combinational mux of master gnt_idx.
  - wbs_cyc_o = wbm_cyc_i[gnt_idx]; wbs_stb_o = wbm_stb_i[gnt_idx] & wbm_cyc_i[gnt_idx].
  - wbs_ack_i, wbs_err_i and wbs_rty_i route only to bit gnt_idx; all other bits are 0.
  - Grant is held while wbm_cyc_i[gnt_idx]=1, regardless of stb, cti or other requests. Bursts and RMW sequences are atomic.
- BUSY exit:
  - When wbm_cyc_i[gnt_idx]=0, go to IDLE the same edge and set ptr = gnt_idx+1 (mod NUM_MASTERS).
  - The next arbitration occurs in IDLE on the following cycle.
  - There is always at least one idle cycle between grants.
- grant_o is one-hot of gnt_idx in BUSY and 0 in IDLE.
- While IDLE, wbs_cyc_o and wbs_stb_o are 0. Other slave outputs may mux master ptr (don't care).
- Simultaneous requests are resolved purely by ptr. A master requesting continuously is served at most once per NUM_MASTERS grants when others are pending.
- Master abort: cyc dropped mid-transfer removes wbs_cyc_o in the same cycle (combinational). A late slave ack after the abort is discarded.
- Reset mid-transfer: wbs_cyc_o and wbs_stb_o drop asynchronously, and the state returns to IDLE with ptr=0.
- wbm_dat_o = wbs_dat_i always.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and on any ack/err/rty.
  - It increments each BUSY cycle with wbs_stb_o=1 and no ack/err/rty.
  - When it reaches TIMEOUT, assert wbm_err_o[gnt_idx] for exactly one cycle, force wbs_stb_o=0 in that cycle, and clear the counter.
  - The grant is still held until the master drops cyc.
- Without the macro: no counter logic. A hung slave stalls the bus indefinitely.

Test Plan:
- Single master 0, classic read to 0x100 with slave ack after 2 cycles -> wbs_cyc_o rises 1 cycle after wbm_cyc_i[0], wbm_ack_o=3'b001 for one cycle, grant_o=3'b001 during the cycle, ptr=1 afterwards.
- Masters 0, 1 and 2 request simultaneously after reset, each doing one single-beat cycle and then re-requesting -> grant order 0,1,2,0,1,2, with one idle cycle between grants.
- Master 1 runs a 4-beat incrementing burst (cti 010,010,010,111) while master 2 requests -> master 2 is not granted until master 1 drops cyc after the 4th ack; 4 acks reach master 1 only.
- Master 0 drops cyc after 1 stb cycle, before ack; slave acks next cycle -> wbs_cyc_o=0 in the drop cycle, no ack seen on any master, state returns to IDLE.
- wb_rst_i pulsed mid-burst (asynchronously, between edges) -> wbs_cyc_o and grant_o go 0 immediately, and the next arbitration starts from master 0.
- WB_ARB_TIMEOUT_EN with TIMEOUT=8, slave never acks master 2 -> wbm_err_o[2] pulses after 8 stalled cycles, and grant is released when master 2 drops cyc.
